// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared main-memory data port.
// Define MEM_ARB_LOCK_EN to let requester 1 hold the port via i_req1_lock.
module mem_port_arbiter #(
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned RR_INIT      = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_req0_stb,
  input  logic                            i_req0_we,
  input  logic [31:0]                     i_req0_addr,
  input  logic [31:0]                     i_req0_wdata,
  input  logic [3:0]                      i_req0_mask,
  output logic                            o_req0_ack,
  output logic                            o_req0_err,
  output logic [31:0]                     o_req0_rdata,
  input  logic                            i_req1_stb,
  input  logic                            i_req1_we,
  input  logic [31:0]                     i_req1_addr,
  input  logic [31:0]                     i_req1_wdata,
  input  logic [3:0]                      i_req1_mask,
  input  logic                            i_req1_lock,
  output logic                            o_req1_ack,
  output logic                            o_req1_err,
  output logic [31:0]                     o_req1_rdata,
  output logic [$clog2(MEMORY_DEPTH)-1:0] o_mem_addr,
  output logic [31:0]                     o_mem_wdata,
  output logic [3:0]                      o_mem_mask,
  output logic                            o_mem_wr_en,
  input  logic [31:0]                     i_mem_rdata,
  output logic                            o_busy
);

  localparam int unsigned AW     = $clog2(MEMORY_DEPTH);
  localparam logic [31:0] DepthW = 32'(MEMORY_DEPTH);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e          r_state;
  logic            r_owner;
  logic            r_last;
  logic            r_err;
  logic            r_req0_ack;
  logic            r_req0_err;
  logic [31:0]     r_req0_rdata;
  logic            r_req1_ack;
  logic            r_req1_err;
  logic [31:0]     r_req1_rdata;
  logic [AW-1:0]   r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic [3:0]      r_mem_mask;
  logic            r_mem_wr_en;
  logic            r_busy;

  logic            w_any;
  logic            w_grant1;
  logic            w_we;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [3:0]      w_mask;
  logic            w_in_range;

`ifndef MEM_ARB_LOCK_EN
  logic w_unused_lock;
  assign w_unused_lock = i_req1_lock;
`endif

  always_comb begin
    w_any = i_req0_stb | i_req1_stb;
    // On a conflict the requester that was not granted last wins.
`ifdef MEM_ARB_LOCK_EN
    w_grant1 = i_req1_stb & (~i_req0_stb | ~r_last | (i_req1_lock & r_last));
`else
    w_grant1 = i_req1_stb & (~i_req0_stb | ~r_last);
`endif
    w_we       = w_grant1 ? i_req1_we    : i_req0_we;
    w_addr     = w_grant1 ? i_req1_addr  : i_req0_addr;
    w_wdata    = w_grant1 ? i_req1_wdata : i_req0_wdata;
    w_mask     = w_grant1 ? i_req1_mask  : i_req0_mask;
    w_in_range = (w_addr < DepthW);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last       <= 1'(RR_INIT);
      r_err        <= 1'b0;
      r_req0_ack   <= 1'b0;
      r_req0_err   <= 1'b0;
      r_req0_rdata <= '0;
      r_req1_ack   <= 1'b0;
      r_req1_err   <= 1'b0;
      r_req1_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_mask   <= '0;
      r_mem_wr_en  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_owner     <= w_grant1;
            r_last      <= w_grant1;
            r_err       <= ~w_in_range;
            r_mem_addr  <= w_addr[AW-1:0];
            r_mem_wdata <= w_wdata;
            r_mem_mask  <= w_mask;
            r_mem_wr_en <= w_we & w_in_range;
            r_busy      <= 1'b1;
            r_state     <= StAccess;
          end
        end
        StAccess: begin
          r_mem_wr_en <= 1'b0;
          if (r_owner) begin
            r_req1_rdata <= r_err ? 32'h0 : i_mem_rdata;
            r_req1_ack   <= 1'b1;
            r_req1_err   <= r_err;
          end else begin
            r_req0_rdata <= r_err ? 32'h0 : i_mem_rdata;
            r_req0_ack   <= 1'b1;
            r_req0_err   <= r_err;
          end
          r_state <= StAck;
        end
        StAck: begin
          r_req0_ack <= 1'b0;
          r_req0_err <= 1'b0;
          r_req1_ack <= 1'b0;
          r_req1_err <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req0_ack   = r_req0_ack;
  assign o_req0_err   = r_req0_err;
  assign o_req0_rdata = r_req0_rdata;
  assign o_req1_ack   = r_req1_ack;
  assign o_req1_err   = r_req1_err;
  assign o_req1_rdata = r_req1_rdata;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_mask   = r_mem_mask;
  assign o_mem_wr_en  = r_mem_wr_en;
  assign o_busy       = r_busy;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing the single data port of the combined instruction/data main memory.
- Requester 0 is the core data interface. Requester 1 is a secondary master (program loader / debug / DMA).
- Each request is accepted, sequenced through a fixed IDLE→ACCESS→ACK cycle, and acknowledged with registered read data.
- Round-robin priority on simultaneous requests; out-of-range addresses are blocked and flagged.

Parameters:
- MEMORY_DEPTH, 1024: memory size in bytes. Memory-side address width is $clog2(MEMORY_DEPTH).
- RR_INIT, 1: reset value of the last-granted pointer. With 1, requester 0 wins the first conflict.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req0_stb  in  1  requester 0 request; held until o_req0_ack
- i_req0_we  in  1  requester 0 write (1) / read (0)
- i_req0_addr  in  32  requester 0 byte address
- i_req0_wdata  in  32  requester 0 store data
- i_req0_mask  in  4  requester 0 byte-write mask
- o_req0_ack  out  1  one-cycle completion pulse
- o_req0_err  out  1  valid with ack; address out of range
- o_req0_rdata  out  32  read data, valid with ack
- i_req1_stb, i_req1_we, i_req1_addr, i_req1_wdata, i_req1_mask, o_req1_ack, o_req1_err, o_req1_rdata: same as requester 0
- i_req1_lock  in  1  bus lock request (see Optional Feature)
- o_mem_addr  out  $clog2(MEMORY_DEPTH)  memory byte address
- o_mem_wdata  out  32  memory write data
- o_mem_mask  out  4  memory write mask
- o_mem_wr_en  out  1  memory write enable
- i_mem_rdata  in  32  combinational memory read data
- o_busy  out  1  high whenever state is not IDLE

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; last-granted pointer = RR_INIT.
- Registers: state, owner, latched request fields, err flag.

States:
- IDLE: if no stb, stay. If exactly one stb, grant it. If both, grant the requester not equal to the last-granted pointer.
  - On grant: latch we/addr/wdata/mask, set owner, update pointer, go to ACCESS.
  - At the same edge, drive o_mem_addr/o_mem_wdata/o_mem_mask.
  - o_mem_wr_en = we AND address in range.
- ACCESS: memory port stable for exactly one cycle; the write commits at the end of this cycle.
  - At the end of ACCESS: capture i_mem_rdata into the owner's rdata register (0 if err); drop o_mem_wr_en to 0; go to ACK.
- ACK: owner's ack = 1 for this one cycle; err valid alongside ack. Go to IDLE.

Rules:
- Latency: stb seen in IDLE at cycle N → ACCESS at N+1 → ack at N+2. Minimum 3 cycles per transaction.
- Back-to-back: the earliest next grant is from IDLE at N+3.
- A requester must deassert stb on the cycle after ack. A stb still high in IDLE is treated as a new request.
- Out of range: address ≥ MEMORY_DEPTH sets err. The write is suppressed, rdata is 0, and ack is still given.
  - o_mem_addr carries the truncated low bits.
- Ack and rdata are given only to the owner. The non-owner's rdata keeps its previous value.
- Request inputs are ignored outside IDLE. Changing them mid-transaction has no effect.
- Reset mid-transaction aborts immediately: no ack, wr_en 0. A write in ACCESS may or may not have committed.

Optional Feature:
- Macro MEM_ARB_LOCK_EN.
- Defined:
  - While i_req1_lock=1 and requester 1 was the last grantee, requester 1 wins all conflicts in IDLE. This allows atomic multi-word loads.
  - Requester 0 is served only when i_req1_stb=0.
  - Lock is sampled only in IDLE.
- Not defined: i_req1_lock is ignored; pure round-robin.

Test Plan:
- Req0 read, addr 0x10, mem word 0xDEADBEEF → o_mem_addr=0x10 at N+1, o_req0_ack=1 with rdata 0xDEADBEEF at N+2, o_busy high N+1..N+2.
- Req1 write addr 0x20, data 0x11223344, mask 4'b0011 → wr_en high exactly one cycle, memory word low half 0x3344 and upper bytes unchanged; ack1 at N+2, ack0 never.
- Both stb held continuously after reset, RR_INIT=1 → grants alternate 0,1,0,1; each ack is 3 cycles apart.
- Req0 write addr 0x400 (MEMORY_DEPTH=1024) → wr_en never high, ack0 with err0=1, rdata0=0.
- Reset asserted during ACCESS → all outputs 0 asynchronously, no ack; after release, a new req0 read completes normally.
- With MEM_ARB_LOCK_EN: lock=1, both stb high, last grant=1 → requester 1 granted three times in a row; lock=0 → requester 0 granted next.
